// File: rtl/jpeg_fb_writer_pkg.sv
// Shared definitions for the JPEG framebuffer writer: write-request layout,
// byte-strobe constants and the RGB565 packer.
package jpeg_fb_writer_pkg;

  localparam logic [3:0] STRB_LO  = 4'h3;
  localparam logic [3:0] STRB_HI  = 4'hC;
  localparam logic [3:0] STRB_ALL = 4'hF;

  // 'last' marks the final memory write of a frame
  typedef struct packed {
    logic        last;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_req_t;

  function automatic logic [15:0] rgb565(input logic [7:0] r,
                                         input logic [7:0] g,
                                         input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

  function automatic wr_req_t lo_req(input logic [29:0] waddr,
                                     input logic [15:0] pix);
    wr_req_t r;
    r.last = 1'b0;
    r.addr = {waddr, 2'b00};
    r.data = {16'h0000, pix};
    r.strb = STRB_LO;
    return r;
  endfunction

endpackage

// File: rtl/jpeg_fb_writer_fifo.sv
// Show-ahead write-request FIFO; accepts up to two pushes and one pop per cycle.
module jpeg_fb_fifo
  import jpeg_fb_writer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               push_cnt_i,
  input  wr_req_t                  push0_i,
  input  wr_req_t                  push1_i,
  input  logic                     pop_i,
  output wr_req_t                  head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  wr_req_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [AW-1:0]   wr_ptr_nxt;
  logic            pop_ok;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign count_o    = count_q;
  assign head_o     = mem_q[rd_ptr_q];
  assign pop_ok     = pop_i && !empty_o;
  assign wr_ptr_nxt = wr_ptr_q + AW'(1);

  // Space is guaranteed by the producer, so pushes are never refused here.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_cnt_i != 2'd0) begin
        mem_q[wr_ptr_q] <= push0_i;
      end
      if (push_cnt_i == 2'd2) begin
        mem_q[wr_ptr_nxt] <= push1_i;
      end
      wr_ptr_q <= wr_ptr_q + AW'(push_cnt_i);
      rd_ptr_q <= rd_ptr_q + AW'(pop_ok);
      count_q  <= count_q + CW'(push_cnt_i) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/jpeg_fb_writer.sv
// Framebuffer writer: RGB888 pixels -> RGB565, pair-merged 32-bit strobed
// writes through a small FIFO, with end-of-frame tracking.
module jpeg_fb_writer
  import jpeg_fb_writer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] cfg_base_i,
  input  logic [15:0] cfg_stride_i,
  input  logic        inport_valid_i,
  input  logic [15:0] inport_width_i,
  input  logic [15:0] inport_height_i,
  input  logic [15:0] inport_pixel_x_i,
  input  logic [15:0] inport_pixel_y_i,
  input  logic [7:0]  inport_pixel_r_i,
  input  logic [7:0]  inport_pixel_g_i,
  input  logic [7:0]  inport_pixel_b_i,
  output logic        inport_accept_o,
  output logic        mem_valid_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_strb_o,
  input  logic        mem_accept_i,
  output logic        frame_done_o,
  output logic        busy_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0] fifo_count;
  logic [CW-1:0] fifo_free;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  wr_req_t       fifo_head;
  logic [1:0]    push_cnt;
  wr_req_t       push0;
  wr_req_t       push1;

  logic          s1_valid_q;
  logic          s1_odd_q;
  logic          s1_last_q;
  logic [29:0]   s1_waddr_q;
  logic [15:0]   s1_pix_q;
  logic [31:0]   pix_cnt_q;
  logic [31:0]   base_q;
  logic [15:0]   stride_q;

  logic          hold_valid_q, hold_valid_d;
  logic [29:0]   hold_waddr_q, hold_waddr_d;
  logic [15:0]   hold_pix_q,   hold_pix_d;
  logic          hold_match;

  logic          s1_adv;
  logic          pix_acc;
  logic          first_px;
  logic          px_last;
  logic [31:0]   base_sel;
  logic [15:0]   stride_sel;
  logic [31:0]   line_off;
  logic [31:0]   byte_addr;
  logic [31:0]   frame_px;

  logic          pre_en, main_en, tail_en;
  wr_req_t       pre_req, main_req, tail_req;

  logic          unused_bits;

  // Free space uses the registered count only; a concurrent pop is not credited.
  assign fifo_free       = CW'(FIFO_DEPTH) - fifo_count;
  assign s1_adv          = s1_valid_q && (fifo_free >= CW'(2));
  assign inport_accept_o = !s1_valid_q || s1_adv;
  assign pix_acc         = inport_valid_i && inport_accept_o;

  assign first_px   = (pix_cnt_q == '0);
  assign base_sel   = first_px ? cfg_base_i   : base_q;
  assign stride_sel = first_px ? cfg_stride_i : stride_q;
  assign line_off   = {16'h0000, inport_pixel_y_i} * {16'h0000, stride_sel};
  assign byte_addr  = base_sel + line_off + {15'h0000, inport_pixel_x_i, 1'b0};
  assign frame_px   = {16'h0000, inport_width_i} * {16'h0000, inport_height_i};
  assign px_last    = (frame_px != '0) && ((pix_cnt_q + 32'd1) == frame_px);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_odd_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_waddr_q <= '0;
      s1_pix_q   <= '0;
      pix_cnt_q  <= '0;
      base_q     <= '0;
      stride_q   <= '0;
    end else begin
      if (pix_acc) begin
        s1_valid_q <= 1'b1;
        s1_odd_q   <= inport_pixel_x_i[0];
        s1_last_q  <= px_last;
        s1_waddr_q <= byte_addr[31:2];
        s1_pix_q   <= rgb565(inport_pixel_r_i, inport_pixel_g_i, inport_pixel_b_i);
        pix_cnt_q  <= px_last ? '0 : pix_cnt_q + 32'd1;
        if (first_px) begin
          base_q   <= cfg_base_i;
          stride_q <= cfg_stride_i;
        end
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  assign hold_match = hold_valid_q && (hold_waddr_q == s1_waddr_q);

  // Up to three candidate writes in order: stale hold, the pixel itself, and a
  // frame-end flush. Main and tail are mutually exclusive, so at most two fire.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_waddr_d = hold_waddr_q;
    hold_pix_d   = hold_pix_q;
    pre_en       = 1'b0;
    main_en      = 1'b0;
    tail_en      = 1'b0;
    pre_req      = '0;
    main_req     = '0;
    tail_req     = '0;
    if (s1_adv) begin
      if (hold_valid_q && !(s1_odd_q && hold_match)) begin
        pre_en       = 1'b1;
        pre_req      = lo_req(hold_waddr_q, hold_pix_q);
        hold_valid_d = 1'b0;
      end
      if (s1_odd_q) begin
        main_en       = 1'b1;
        main_req.addr = {s1_waddr_q, 2'b00};
        main_req.data = {s1_pix_q, hold_match ? hold_pix_q : 16'h0000};
        main_req.strb = hold_match ? STRB_ALL : STRB_HI;
        hold_valid_d  = 1'b0;
      end else begin
        hold_valid_d = 1'b1;
        hold_waddr_d = s1_waddr_q;
        hold_pix_d   = s1_pix_q;
      end
      if (s1_last_q && hold_valid_d) begin
        tail_en      = 1'b1;
        tail_req     = lo_req(hold_waddr_d, hold_pix_d);
        hold_valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    push_cnt = 2'(pre_en) + 2'(main_en) + 2'(tail_en);
    push0    = pre_en ? pre_req : (main_en ? main_req : tail_req);
    push1    = main_en ? main_req : tail_req;
    if (s1_adv && s1_last_q) begin
      if (push_cnt == 2'd2) begin
        push1.last = 1'b1;
      end else begin
        push0.last = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid_q <= 1'b0;
      hold_waddr_q <= '0;
      hold_pix_q   <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_waddr_q <= hold_waddr_d;
      hold_pix_q   <= hold_pix_d;
    end
  end

  jpeg_fb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_cnt_i (push_cnt),
    .push0_i    (push0),
    .push1_i    (push1),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign fifo_pop     = !fifo_empty && mem_accept_i;
  assign mem_valid_o  = !fifo_empty;
  assign mem_addr_o   = fifo_empty ? '0 : fifo_head.addr;
  assign mem_data_o   = fifo_empty ? '0 : fifo_head.data;
  assign mem_strb_o   = fifo_empty ? '0 : fifo_head.strb;
  assign frame_done_o = fifo_pop && fifo_head.last;

  // Busy drops in the very cycle the last queued write is taken.
  assign busy_o = s1_valid_q || hold_valid_q || (fifo_count > CW'(1)) ||
                  ((fifo_count == CW'(1)) && !fifo_pop);

  assign unused_bits = ^{byte_addr[1:0], fifo_full};

endmodule
